// File: rtl/grant_demux.sv
// Receive-side demultiplexer for the arbitrated stream: routes each granted word
// into one of five per-channel FIFOs and flags lossy cases with sticky errors.
module grant_demux #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       grant,
  input  logic [WIDTH-1:0] data_in,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic [WIDTH-1:0] out_data_0,
  output logic [WIDTH-1:0] out_data_1,
  output logic [WIDTH-1:0] out_data_2,
  output logic [WIDTH-1:0] out_data_3,
  output logic [WIDTH-1:0] out_data_4,
  output logic [4:0]       overflow,
  output logic             grant_err
);

  localparam int unsigned NCH = 5;

  logic             onehot;
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;
  logic [WIDTH-1:0] head [NCH];

  assign onehot = (grant != 5'd0) && ((grant & (grant - 5'd1)) == 5'd0);
  assign push   = (in_valid && onehot) ? grant : 5'd0;
  assign pop    = out_ready & out_valid;

  // Malformed grant while a word is presented: word is dropped, flag sticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_err <= 1'b0;
    end else if (in_valid && !onehot) begin
      grant_err <= 1'b1;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             accept;
    logic             valid_q;
    logic             ovf_q;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign accept = push[ch] && ((count != (AW+1)'(DEPTH)) || pop[ch]);

    always_comb begin
      count_nxt = count;
      case ({accept, pop[ch]})
        2'b10:   count_nxt = count + (AW+1)'(1);
        2'b01:   count_nxt = count - (AW+1)'(1);
        default: count_nxt = count;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          mem[k] <= '0;
        end
      end else begin
        if (accept) begin
          mem[wr_ptr] <= data_in;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop[ch]) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push[ch] && !accept) begin
          ovf_q <= 1'b1;
        end
        count   <= count_nxt;
        valid_q <= (count_nxt != '0);
      end
    end

    assign out_valid[ch] = valid_q;
    assign overflow[ch]  = ovf_q;
    assign head[ch]      = mem[rd_ptr];
  end

  assign out_data_0 = head[0];
  assign out_data_1 = head[1];
  assign out_data_2 = head[2];
  assign out_data_3 = head[3];
  assign out_data_4 = head[4];

endmodule

// File: tb/tb_grant_demux.sv
// Scoreboard bench for grant_demux: per-channel expected-word queues filled on
// push and drained/compared on pop, plus flag and valid tracking every cycle.
module tb_grant_demux;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  grant;
  logic [15:0] data_in;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic [15:0] od [5];
  logic [4:0]  overflow;
  logic        grant_err;

  int tests = 0;
  int fails = 0;

  logic [15:0] sbq [5][$];
  logic [4:0]  m_ovf;
  logic        m_gerr;

  grant_demux dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .grant(grant),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data_0(od[0]), .out_data_1(od[1]), .out_data_2(od[2]),
    .out_data_3(od[3]), .out_data_4(od[4]),
    .overflow(overflow), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_valid();
    logic [4:0] v;
    for (int c = 0; c < 5; c++) v[c] = (sbq[c].size() != 0);
    return v;
  endfunction

  // One clock: check state at negedge, drive inputs, advance model, wait edge.
  task automatic step(input logic iv, input logic [4:0] g, input logic [15:0] d,
                      input logic [4:0] rdy);
    int idx;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(model_valid()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("grant_err", 32'(grant_err), 32'(m_gerr));
    in_valid  = iv;
    grant     = g;
    data_in   = d;
    out_ready = rdy;
    for (int c = 0; c < 5; c++) begin
      if (rdy[c] && sbq[c].size() != 0) begin
        chk($sformatf("pop_data%0d", c), 32'(od[c]), 32'(sbq[c][0]));
        void'(sbq[c].pop_front());
      end
    end
    if (iv) begin
      if ($onehot(g)) begin
        idx = 0;
        for (int c = 0; c < 5; c++) if (g[c]) idx = c;
        if (sbq[idx].size() < DEPTH) sbq[idx].push_back(d);
        else m_ovf[idx] = 1'b1;
      end else begin
        m_gerr = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  task automatic model_clear();
    for (int c = 0; c < 5; c++) sbq[c].delete();
    m_ovf  = '0;
    m_gerr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; grant = '0; data_in = '0; out_ready = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_gerr", 32'(grant_err), 32'd0);
    chk("rst_data0", 32'(od[0]), 32'd0);

    // single word to channel 2, latency 1, then pop
    step(1, 5'b00100, 16'h00C, 5'b0);
    step(0, 5'b0, 16'h0, 5'b00100);
    step(0, 5'b0, 16'h0, 5'b0);

    // overflow on channel 0
    step(1, 5'b00001, 16'h00A, 5'b0);
    step(1, 5'b00001, 16'h00B, 5'b0);
    step(1, 5'b00001, 16'h00C, 5'b0);
    step(1, 5'b00001, 16'h00D, 5'b0);
    step(1, 5'b00001, 16'h00E, 5'b0);
    repeat (4) step(0, 5'b0, 16'h0, 5'b00001);
    step(0, 5'b0, 16'h0, 5'b0);

    // channel 3 full, simultaneous push and pop, pointer wrap
    step(1, 5'b01000, 16'h030, 5'b0);
    step(0, 5'b0, 16'h0, 5'b01000);
    for (int i = 1; i <= 4; i++) step(1, 5'b01000, 16'(16'h030 + i), 5'b0);
    step(1, 5'b01000, 16'h0FF, 5'b01000);
    repeat (5) step(0, 5'b0, 16'h0, 5'b01000);

    // bad grants
    step(1, 5'b01100, 16'h123, 5'b0);
    step(1, 5'b00000, 16'h124, 5'b0);
    step(0, 5'b11111, 16'h125, 5'b0);

    // interleaved channels 1 and 4, popped together
    step(1, 5'b00010, 16'h00B, 5'b0);
    step(1, 5'b10000, 16'h00E, 5'b0);
    step(0, 5'b0, 16'h0, 5'b10010);
    step(0, 5'b0, 16'h0, 5'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [4:0] g;
      g = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
      step(1'($urandom_range(0, 2) != 0), g, 16'($urandom), 5'($urandom));
    end

    // async reset mid-sequence with words queued and flags set
    for (int i = 0; i < 3; i++) step(1, 5'b00010, 16'(16'h200 + i), 5'b0);
    step(1, 5'b00011, 16'h2FF, 5'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    in_valid = 1'b0; out_ready = '0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_gerr", 32'(grant_err), 32'd0);
    chk("mid_rst_data1", 32'(od[1]), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    step(1, 5'b00010, 16'h3A5, 5'b0);
    step(0, 5'b0, 16'h0, 5'b00010);
    step(0, 5'b0, 16'h0, 5'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
